// File: rtl/read_packet_sender.sv
// Output-port packet sender: picks the highest-priority non-empty queue, streams its head
// packet out of packet SRAM through a 3-entry credit-managed FIFO, and pops the queue on eop.
module read_packet_sender #(
    parameter int data_width        = 256,
    parameter int num_of_priorities = 8,
    parameter int priority_width    = 3,
    parameter int len_width         = 7
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   en,
    input  logic [num_of_priorities-1:0]           q_nonempty,
    input  logic [num_of_priorities*len_width-1:0] q_head_len,
    output logic [num_of_priorities-1:0]           q_pop,
    output logic                                   rd_en,
    output logic [priority_width-1:0]              rd_prio,
    output logic [len_width-1:0]                   rd_word,
    input  logic [data_width-1:0]                  rd_data,
    output logic [data_width-1:0]                  out_data,
    output logic                                   out_valid,
    output logic                                   out_sop,
    output logic                                   out_eop,
    input  logic                                   out_ready,
    output logic                                   busy
);

    localparam int DEPTH = 3;

    typedef enum logic [1:0] {IDLE, SEND, DRAIN} state_t;

    state_t                    state, state_nxt;
    logic [priority_width-1:0] cur_prio, sel_prio;
    logic [len_width-1:0]      cur_len, sel_len, word_cnt;
    logic                      arb, issue, last_issue, pop;
    logic                      inflight, inflight_sop, inflight_eop;
    logic [1:0]                count, wr_ptr, rd_ptr;
    logic [data_width-1:0]     wr_data;
    logic [data_width-1:0]     fifo_data [DEPTH];
    logic [DEPTH-1:0]          fifo_sop, fifo_eop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
        return (ptr == 2'(DEPTH - 1)) ? 2'd0 : ptr + 2'd1;
    endfunction

    // Highest index wins; a zero-length head is sent as a single word.
    always_comb begin
        sel_prio = '0;
        sel_len  = '0;
        for (int p = 0; p < num_of_priorities; p++) begin
            if (q_nonempty[p]) begin
                sel_prio = priority_width'(p);
                sel_len  = q_head_len[p*len_width +: len_width];
            end
        end
        if (sel_len == '0)
            sel_len = len_width'(1);
    end

    // Credit covers both the FIFO and the word still in flight from SRAM.
    assign arb        = (state == IDLE) && en && (|q_nonempty);
    assign issue      = (state == SEND) && ((3'(count) + 3'(inflight)) < 3'(DEPTH));
    assign last_issue = issue && (word_cnt == cur_len - len_width'(1));
    assign pop        = out_valid && out_ready;

    always_comb begin
        state_nxt = state;
        q_pop     = '0;
        case (state)
            IDLE:  if (arb) state_nxt = SEND;
            SEND:  if (last_issue) state_nxt = DRAIN;
            DRAIN: begin
                if (pop && out_eop) begin
                    q_pop[cur_prio] = 1'b1;
                    state_nxt       = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cur_prio     <= '0;
            cur_len      <= '0;
            word_cnt     <= '0;
            inflight     <= 1'b0;
            inflight_sop <= 1'b0;
            inflight_eop <= 1'b0;
        end else begin
            state        <= state_nxt;
            inflight     <= issue;
            inflight_sop <= issue && (word_cnt == '0);
            inflight_eop <= last_issue;
            if (arb) begin
                cur_prio <= sel_prio;
                cur_len  <= sel_len;
                word_cnt <= '0;
            end else if (issue) begin
                word_cnt <= word_cnt + len_width'(1);
            end
        end
    end

    // First beat carries the queue index in the field the write side decodes as priority.
    always_comb begin
        wr_data = rd_data;
        if (inflight_sop)
            wr_data[4 +: priority_width] = cur_prio;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_sop <= '0;
            fifo_eop <= '0;
        end else begin
            if (inflight) begin
                fifo_sop[wr_ptr] <= inflight_sop;
                fifo_eop[wr_ptr] <= inflight_eop;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            count <= count + 2'(inflight) - 2'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (inflight)
            fifo_data[wr_ptr] <= wr_data;
    end

    assign out_valid = (count != '0);
    assign out_sop   = out_valid & fifo_sop[rd_ptr];
    assign out_eop   = out_valid & fifo_eop[rd_ptr];
    assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
    assign rd_en     = issue;
    assign rd_prio   = issue ? cur_prio : '0;
    assign rd_word   = issue ? word_cnt : '0;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_read_packet_sender.sv
// Bench for read_packet_sender: queue/SRAM model plus an expected-beat scoreboard built from
// the priority rule (highest queue first, FIFO within a queue).
module tb_read_packet_sender;

    localparam int DW = 256;
    localparam int NP = 8;
    localparam int PW = 3;
    localparam int LW = 7;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             en = 1'b0;
    logic [NP-1:0]    q_nonempty = '0;
    logic [NP*LW-1:0] q_head_len = '0;
    logic [NP-1:0]    q_pop;
    logic             rd_en;
    logic [PW-1:0]    rd_prio;
    logic [LW-1:0]    rd_word;
    logic [DW-1:0]    rd_data = '0;
    logic [DW-1:0]    out_data;
    logic             out_valid, out_sop, out_eop;
    logic             out_ready = 1'b1;
    logic             busy;

    read_packet_sender #(.data_width(DW), .num_of_priorities(NP), .priority_width(PW), .len_width(LW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .q_nonempty(q_nonempty), .q_head_len(q_head_len),
        .q_pop(q_pop), .rd_en(rd_en), .rd_prio(rd_prio), .rd_word(rd_word), .rd_data(rd_data),
        .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {logic [DW-1:0] data; bit sop; bit eop; int prio;} beat_t;
    typedef struct {int c; int p; int w;} rd_t;

    beat_t         exp_q[$];
    int            qlen[NP][$];
    int            qid[NP][$];
    rd_t           rd_log[$];
    int            sop_cyc[$], eop_cyc[$], pop_cyc[$];
    logic [NP-1:0] pop_vec[$];
    int            total = 0, bad = 0, cyc = 0, issued = 0, accepted = 0, next_id = 1;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data;
    logic          prev_sop, prev_eop;

    function automatic logic [DW-1:0] word_val(int p, int id, int w);
        logic [DW-1:0] v;
        for (int i = 0; i < DW/32; i++)
            v[i*32 +: 32] = (32'(id) * 32'h9E3779B1) ^ (32'(w) * 32'h85EBCA77) ^ (32'(i) * 32'hC2B2AE3D) ^ (32'(p) << 28);
        return v;
    endfunction

    task automatic refresh_q();
        for (int p = 0; p < NP; p++) begin
            q_nonempty[p] = (qlen[p].size() != 0);
            q_head_len[p*LW +: LW] = (qlen[p].size() != 0) ? LW'(qlen[p][0]) : '0;
        end
    endtask

    task automatic add_pkt(input int p, input int len, output int id);
        id = next_id++;
        qlen[p].push_back(len);
        qid[p].push_back(id);
        refresh_q();
    endtask

    task automatic expect_pkt(input int p, input int len, input int id);
        beat_t b;
        int n;
        n = (len == 0) ? 1 : len;
        for (int w = 0; w < n; w++) begin
            b.data = word_val(p, id, w);
            if (w == 0) b.data[6:4] = 3'(p);
            b.sop = (w == 0);
            b.eop = (w == n - 1);
            b.prio = p;
            exp_q.push_back(b);
        end
    endtask

    // Expected order for everything currently queued: highest queue first, FIFO inside a queue.
    task automatic expect_all_queued();
        for (int p = NP - 1; p >= 0; p--)
            for (int k = 0; k < qlen[p].size(); k++)
                expect_pkt(p, qlen[p][k], qid[p][k]);
    endtask

    task automatic clear_logs();
        rd_log.delete(); sop_cyc.delete(); eop_cyc.delete(); pop_cyc.delete(); pop_vec.delete();
    endtask

    // One clock: monitor at negedge, then SRAM response and queue bookkeeping just after posedge.
    task automatic tick();
        beat_t e;
        logic [NP-1:0] exp_pop, popv;
        bit s_en;
        int s_p, s_w;
        rd_t r;
        @(negedge clk);
        if (rd_en) begin
            issued++;
            r.c = cyc; r.p = int'(rd_prio); r.w = int'(rd_word);
            rd_log.push_back(r);
        end
        total++;
        if (issued - accepted > 3) begin
            bad++;
            $display("FAIL occupancy: got %0d outstanding want <= 3 (cycle %0d)", issued - accepted, cyc);
        end
        if (prev_stall) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== prev_data || out_sop !== prev_sop || out_eop !== prev_eop) begin
                bad++;
                $display("FAIL stall_stable: got v=%b sop=%b eop=%b data=%h want v=1 sop=%b eop=%b data=%h",
                         out_valid, out_sop, out_eop, out_data, prev_sop, prev_eop, prev_data);
            end
        end
        exp_pop = '0;
        if (out_valid && out_ready) begin
            accepted++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_beat: got beat data=%h want no beat (cycle %0d)", out_data, cyc);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e.data || out_sop !== e.sop || out_eop !== e.eop) begin
                    bad++;
                    $display("FAIL beat: got data=%h sop=%b eop=%b want data=%h sop=%b eop=%b",
                             out_data, out_sop, out_eop, e.data, e.sop, e.eop);
                end
                if (e.eop) exp_pop[e.prio] = 1'b1;
            end
            if (out_sop) sop_cyc.push_back(cyc);
            if (out_eop) eop_cyc.push_back(cyc);
        end
        total++;
        if (q_pop !== exp_pop) begin
            bad++;
            $display("FAIL q_pop: got %b want %b (cycle %0d)", q_pop, exp_pop, cyc);
        end
        popv = q_pop;
        if (popv != '0) begin
            pop_cyc.push_back(cyc);
            pop_vec.push_back(popv);
        end
        prev_stall = out_valid && !out_ready;
        prev_data = out_data; prev_sop = out_sop; prev_eop = out_eop;
        s_en = rd_en; s_p = int'(rd_prio); s_w = int'(rd_word);
        @(posedge clk);
        #1;
        cyc++;
        if (s_en)
            rd_data = word_val(s_p, (qid[s_p].size() != 0) ? qid[s_p][0] : -1, s_w);
        else
            for (int i = 0; i < DW/32; i++) rd_data[i*32 +: 32] = $urandom();
        for (int p = 0; p < NP; p++)
            if (popv[p] && qlen[p].size() != 0) begin
                void'(qlen[p].pop_front());
                void'(qid[p].pop_front());
            end
        refresh_q();
    endtask

    task automatic run_until_done(input int budget, input bit rand_ready);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        out_ready = 1'b1;
        total++;
        if (exp_q.size() != 0 || busy) begin
            bad++;
            $display("FAIL timeout: got %0d beats pending busy=%b want 0 pending busy=0", exp_q.size(), busy);
        end
        repeat (4) tick();
    endtask

    task automatic check_reset_outputs(input string name);
        total++;
        if ({q_pop, rd_en, rd_prio, rd_word, out_valid, out_sop, out_eop, busy} !== '0 || out_data !== '0) begin
            bad++;
            $display("FAIL %s: got q_pop=%b rd_en=%b rd_prio=%0d rd_word=%0d v=%b sop=%b eop=%b busy=%b data=%h want all zero",
                     name, q_pop, rd_en, rd_prio, rd_word, out_valid, out_sop, out_eop, busy, out_data);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_values");
        rst_n = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (rd_en !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || q_pop !== '0) begin
                bad++;
                $display("FAIL idle_empty: got rd_en=%b v=%b busy=%b q_pop=%b want 0 0 0 0", rd_en, out_valid, busy, q_pop);
            end
        end
    endtask

    task automatic test_priority_order();
        int id, t;
        en = 1'b0;
        add_pkt(2, 3, id);
        add_pkt(5, 4, id);
        expect_all_queued();
        clear_logs();
        t = cyc;
        en = 1'b1;
        run_until_done(200, 1'b0);
        total++;
        if (rd_log.size() != 7) begin
            bad++;
            $display("FAIL prio_reads: got %0d reads want 7", rd_log.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (rd_log[k].c != t + 1 + k || rd_log[k].p != 5 || rd_log[k].w != k) begin
                    bad++;
                    $display("FAIL prio_read%0d: got cyc=%0d prio=%0d word=%0d want cyc=%0d prio=5 word=%0d",
                             k, rd_log[k].c - t, rd_log[k].p, rd_log[k].w, 1 + k, k);
                end
            end
            total++;
            if (rd_log[4].p != 2 || rd_log[4].w != 0 || rd_log[4].c != t + 8) begin
                bad++;
                $display("FAIL prio_next: got cyc=%0d prio=%0d want cyc=8 prio=2", rd_log[4].c - t, rd_log[4].p);
            end
        end
        total++;
        if (sop_cyc.size() < 1 || eop_cyc.size() < 1 || sop_cyc[0] != t + 3 || eop_cyc[0] != t + 6) begin
            bad++;
            $display("FAIL prio_latency: got sop=%0d eop=%0d want sop=3 eop=6",
                     (sop_cyc.size() > 0) ? sop_cyc[0] - t : -1, (eop_cyc.size() > 0) ? eop_cyc[0] - t : -1);
        end
        total++;
        if (pop_vec.size() != 2 || pop_vec[0] !== 8'b0010_0000 || pop_cyc[0] != t + 6 || pop_vec[1] !== 8'b0000_0100) begin
            bad++;
            $display("FAIL prio_pop: got %0d pops first=%b want 2 pops first=00100000 at cycle 6 then 00000100",
                     pop_vec.size(), (pop_vec.size() > 0) ? pop_vec[0] : 8'h0);
        end
    endtask

    task automatic test_single_word();
        int id;
        add_pkt(0, 1, id);
        add_pkt(0, 0, id);
        expect_all_queued();
        clear_logs();
        run_until_done(100, 1'b0);
        total++;
        if (pop_vec.size() != 2 || pop_vec[0] !== 8'h01 || pop_vec[1] !== 8'h01 || rd_log.size() != 2) begin
            bad++;
            $display("FAIL single_word: got pops=%0d reads=%0d want pops=2 (00000001) reads=2", pop_vec.size(), rd_log.size());
        end
    endtask

    task automatic test_random_ready();
        int id;
        add_pkt(4, 10, id);
        expect_all_queued();
        clear_logs();
        run_until_done(400, 1'b1);
        total++;
        if (rd_log.size() != 10) begin
            bad++;
            $display("FAIL stall_reads: got %0d reads want 10", rd_log.size());
        end else begin
            for (int k = 0; k < 10; k++) begin
                total++;
                if (rd_log[k].w != k || rd_log[k].p != 4) begin
                    bad++;
                    $display("FAIL stall_read%0d: got prio=%0d word=%0d want prio=4 word=%0d", k, rd_log[k].p, rd_log[k].w, k);
                end
            end
        end
    endtask

    task automatic test_no_preempt();
        int id1, id7, n, first7;
        add_pkt(1, 5, id1);
        expect_pkt(1, 5, id1);
        clear_logs();
        n = 0;
        while (rd_log.size() < 2 && n < 20) begin tick(); n++; end
        add_pkt(7, 2, id7);
        expect_pkt(7, 2, id7);
        run_until_done(200, 1'b0);
        first7 = -1;
        for (int k = rd_log.size() - 1; k >= 0; k--)
            if (rd_log[k].p == 7) first7 = rd_log[k].c;
        total++;
        if (pop_vec.size() != 2 || pop_vec[0] !== 8'h02 || pop_vec[1] !== 8'h80 || first7 != pop_cyc[0] + 2) begin
            bad++;
            $display("FAIL no_preempt: got pops=%0d first=%b q7 read at %0d want pops 00000010 then 10000000, q7 read 2 after pop",
                     pop_vec.size(), (pop_vec.size() > 0) ? pop_vec[0] : 8'h0, first7 - ((pop_cyc.size() > 0) ? pop_cyc[0] : 0));
        end
    endtask

    task automatic test_reset_abort();
        int id, n;
        add_pkt(3, 6, id);
        expect_pkt(3, 6, id);
        n = 0;
        while (exp_q.size() > 4 && n < 50) begin tick(); n++; end
        total++;
        if (exp_q.size() != 4) begin
            bad++;
            $display("FAIL abort_setup: got %0d beats pending want 4", exp_q.size());
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort_reset");
        exp_q.delete();
        prev_stall = 0;
        issued = 0;
        accepted = 0;
        tick();
        tick();
        rst_n = 1'b1;
        expect_pkt(3, 6, id);
        clear_logs();
        run_until_done(200, 1'b0);
        total++;
        if (rd_log.size() != 6 || rd_log[0].p != 3 || rd_log[0].w != 0 || pop_vec.size() != 1 || pop_vec[0] !== 8'h08) begin
            bad++;
            $display("FAIL abort_resend: got reads=%0d pops=%0d want reads=6 from word 0 of queue 3, one pop 00001000",
                     rd_log.size(), pop_vec.size());
        end
    endtask

    task automatic test_back_to_back();
        int id, p, len;
        en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            p = $urandom_range(0, NP - 1);
            len = $urandom_range(0, 8);
            add_pkt(p, len, id);
        end
        expect_all_queued();
        clear_logs();
        tick();
        en = 1'b1;
        run_until_done(1000, 1'b1);
        total++;
        if (pop_vec.size() != 6) begin
            bad++;
            $display("FAIL b2b_pops: got %0d want 6", pop_vec.size());
        end
    endtask

    initial begin
        refresh_q();
        test_reset();
        test_priority_order();
        test_single_word();
        test_random_ready();
        test_no_preempt();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
